uart_rx_cmd: RTL and testbench

UART receiver for the Segway BLE command path. It is the receive end of the link driven by UART_tx. It deserialises 8N1 frames arriving on RX and presents each byte with a rdy/clr_rdy handshake to the authorisation logic, which consumes 'g' (8'h67) and 's' (8'h73). It also flags framing errors and overruns so the consumer can discard corrupt commands.

---
 rtl/uart_rx_cmd.sv | 81 ++++++++
 tb/tb_uart_rx_cmd.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver with rdy/clr_rdy handshake and framing/overrun flags
module uart_rx_cmd #(
   parameter int BAUD_DIV = 5208,
   parameter int HALF_DIV = BAUD_DIV / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HLOAD  = 16'(HALF_DIV - 1);
   state_t      state_q, state_d;
   logic        rx_s1_q, rx_s2_q, rx_s3_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d, data_q, data_d;
   logic        rdy_q, rdy_d, ferr_q, ferr_d, ovr_q, ovr_d;
   logic        tick, start_edge, done, bad;
   assign start_edge = rx_s3_q & ~rx_s2_q;
   assign tick       = cnt_q == 16'd0;
   assign done       = state_q == STOP & tick & rx_s2_q;
   assign bad        = state_q == STOP & tick & ~rx_s2_q;
   assign rx_data    = data_q;
   assign rdy        = rdy_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   // state and datapath registers; RX is double-synchronised, third flop feeds edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_s1_q <= RX;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end
   // frame sequencing; a high start-bit sample is treated as a glitch and dropped silently
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_edge) state_d = START;
         START:   if (tick) state_d = rx_s2_q ? IDLE : DATA;
         DATA:    if (tick && bit_q == 3'd7) state_d = STOP;
         default: if (tick) state_d = IDLE;
      endcase
   end
   // baud timing, LSB-first shifting and the consumer-facing handshake/flags
   always_comb begin
      cnt_d   = state_q == IDLE ? (start_edge ? HLOAD : cnt_q) : (tick ? RELOAD : cnt_q - 16'd1);
      bit_d   = state_q == START ? 3'd0 : (state_q == DATA && tick) ? bit_q + 3'd1 : bit_q;
      shift_d = (state_q == DATA && tick) ? {rx_s2_q, shift_q[7:1]} : shift_q;
      data_d  = done ? shift_q : data_q;
      rdy_d   = done | (rdy_q & ~clr_rdy);
      ferr_d  = bad;
      ovr_d   = done & rdy_q & ~clr_rdy;
   end
endmodule

// File: tb/tb_uart_rx_cmd.sv
// tb_uart_rx_cmd: scoreboard bench for uart_rx_cmd with directed and random frames
module tb_uart_rx_cmd;
   localparam int B = 16;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy, frame_err, overrun;
   int         tests = 0;
   int         fails = 0;
   typedef struct {bit ferr; bit ovr; logic [7:0] data;} exp_t;
   exp_t       exp_q[$];
   bit         model_rdy = 1'b0;
   logic [7:0] model_last = 8'h00;
   logic       prev_rdy = 1'b0;
   logic [7:0] prev_data = 8'h00;

   uart_rx_cmd #(.BAUD_DIV(B), .HALF_DIV(B / 2)) dut (
      .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
      .rx_data(rx_data), .rdy(rdy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every visible completion or flag is matched against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (frame_err || overrun || (rdy && (!prev_rdy || rx_data != prev_data)))) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {21'd0, frame_err, overrun, rdy, rx_data}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (e.ferr) check("frame_err_event", {21'd0, frame_err, overrun, rdy, rx_data},
                              {21'd0, 1'b1, 1'b0, prev_rdy, e.data});
            else check("byte_event", {21'd0, frame_err, overrun, rdy, rx_data},
                       {21'd0, 1'b0, e.ovr, 1'b1, e.data});
         end
      end
      prev_rdy  = rdy;
      prev_data = rx_data;
   end

   task automatic drive_bit(input logic v);
      RX = v;
      repeat (B) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      RX = 1'b1;
   endtask

   // reference: a good frame delivers its byte, overrunning if unacknowledged and not cleared at completion
   task automatic frame(input logic [7:0] b, input logic stop, input bit clr_at_done);
      exp_t e;
      e.ferr = !stop;
      e.ovr  = stop && model_rdy && !clr_at_done;
      e.data = stop ? b : model_last;
      exp_q.push_back(e);
      if (stop) begin
         model_rdy  = 1'b1;
         model_last = b;
      end
      if (clr_at_done) begin
         fork
            send(b, stop);
            begin
               repeat (B / 2 + 9 * B + 2) @(negedge clk);
               clr_rdy = 1'b1;
               @(negedge clk);
               clr_rdy = 1'b0;
            end
         join
      end else send(b, stop);
   endtask

   task automatic clear();
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy   = 1'b0;
      model_rdy = 1'b0;
      check("rdy_after_clr", {31'd0, rdy}, 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rb;
      logic       rs;
      int         waitc;
      repeat (4) @(negedge clk);
      check("reset_rdy", {31'd0, rdy}, 32'd0);
      check("reset_data", {24'd0, rx_data}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      check("reset_ovr", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      idle(3);
      frame(8'h67, 1'b1, 1'b0);
      idle(2);
      clear();
      frame(8'h67, 1'b1, 1'b0);
      clear();
      frame(8'h73, 1'b1, 1'b0);
      clear();
      frame(8'h67, 1'b1, 1'b0);
      frame(8'h73, 1'b1, 1'b0);
      idle(2);
      check("rdy_held_after_overrun", {31'd0, rdy}, 32'd1);
      check("data_after_overrun", {24'd0, rx_data}, 32'h73);
      clear();
      RX = 1'b0;
      idle(4);
      RX = 1'b1;
      idle(3 * B);
      check("rdy_after_glitch", {31'd0, rdy}, 32'd0);
      frame(8'hA5, 1'b1, 1'b0);
      idle(3);
      frame(8'h3C, 1'b0, 1'b0);
      idle(2 * B);
      check("rdy_kept_on_ferr", {31'd0, rdy}, 32'd1);
      check("data_kept_on_ferr", {24'd0, rx_data}, 32'hA5);
      clear();
      frame(8'h55, 1'b1, 1'b0);
      idle(2);
      clear();
      frame(8'h11, 1'b1, 1'b0);
      frame(8'hFF, 1'b1, 1'b1);
      idle(2);
      check("rdy_on_clr_completion", {31'd0, rdy}, 32'd1);
      check("data_on_clr_completion", {24'd0, rx_data}, 32'hFF);
      clear();
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rst = 1'b1;
      idle(2);
      check("midreset_rdy", {31'd0, rdy}, 32'd0);
      check("midreset_data", {24'd0, rx_data}, 32'd0);
      check("midreset_flags", {30'd0, frame_err, overrun}, 32'd0);
      RX = 1'b1;
      idle(1);
      rst = 1'b0;
      model_rdy  = 1'b0;
      model_last = 8'h00;
      idle(12 * B);
      check("no_rdy_after_abort", {31'd0, rdy}, 32'd0);
      frame(8'h42, 1'b1, 1'b0);
      idle(2);
      check("data_after_abort", {24'd0, rx_data}, 32'h42);
      clear();
      for (int n = 0; n < 40; n++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         frame(rb, rs, 1'b0);
         if (!rs || $urandom_range(0, 1) == 1) idle($urandom_range(2, 20));
         if ($urandom_range(0, 1) == 1) clear();
      end
      waitc = 0;
      while (exp_q.size() != 0 && waitc < 400) begin
         @(negedge clk);
         waitc++;
      end
      idle(4);
      check("pending_expectations", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
